// File: rtl/eth_header_tx.sv
// eth_header_tx: byte-wide Ethernet frame transmitter (preamble, header, payload).
// Define PAD_EN to zero-pad short payloads up to MIN_PAYLOAD bytes.
`timescale 1ns/1ps
module eth_header_tx #(
    parameter int PREAMBLE_LEN = 8,
    parameter int IFG_CYCLES   = 12,
    parameter int MIN_PAYLOAD  = 46
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] dst_addr,
    input  logic [47:0] src_addr,
    input  logic [15:0] type_length,
    input  logic [7:0]  payload_data,
    input  logic        payload_valid,
    input  logic        payload_last,
    output logic        payload_ready,
    output logic [7:0]  data,
    output logic        control,
    output logic        preamble_valid,
    output logic        dst_addr_valid,
    output logic        src_addr_valid,
    output logic        type_length_valid,
    output logic        frame_done,
    output logic        underrun,
    output logic        busy,
    output logic [3:0]  valid_packet_counter
);

`ifdef PAD_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DST, S_SRC, S_TYPE, S_PAY, S_GAP, S_PAD
    } state_t;
    localparam logic [10:0] PAD_TARGET = 11'(MIN_PAYLOAD);
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DST, S_SRC, S_TYPE, S_PAY, S_GAP
    } state_t;
`endif

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    // flags are {preamble, dst, src, type}
    state_t        r_state, w_state;
    logic [15:0]   r_cnt, w_cnt;
    logic [111:0]  r_hdr, w_hdr;
    logic [10:0]   r_pcnt, w_pcnt;
    logic          r_last, w_last;
    logic [3:0]    r_pkt, w_pkt;
    logic [7:0]    r_data, w_data;
    logic          r_ctrl, w_ctrl;
    logic [3:0]    r_flags, w_flags;
    logic          r_done, w_done;
    logic          r_under, w_under;
    logic          w_take;
    logic          w_finish;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hdr   <= '0;
            r_pcnt  <= '0;
            r_last  <= 1'b0;
            r_pkt   <= '0;
            r_data  <= '0;
            r_ctrl  <= 1'b0;
            r_flags <= '0;
            r_done  <= 1'b0;
            r_under <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_hdr   <= w_hdr;
            r_pcnt  <= w_pcnt;
            r_last  <= w_last;
            r_pkt   <= w_pkt;
            r_data  <= w_data;
            r_ctrl  <= w_ctrl;
            r_flags <= w_flags;
            r_done  <= w_done;
            r_under <= w_under;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_hdr    = r_hdr;
        w_pcnt   = r_pcnt;
        w_last   = r_last;
        w_pkt    = r_pkt;
        w_data   = 8'h00;
        w_ctrl   = 1'b0;
        w_flags  = 4'b0000;
        w_done   = 1'b0;
        w_under  = 1'b0;
        w_take   = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_PRE;
                    w_cnt   = '0;
                    w_hdr   = {dst_addr, src_addr, type_length};
                    w_pcnt  = '0;
                    w_last  = 1'b0;
                    w_data  = 8'h55;
                    w_ctrl  = 1'b1;
                    w_flags = 4'b1000;
                end
            end
            S_PRE: begin
                w_ctrl = 1'b1;
                if (r_cnt == PRE_LAST) begin
                    w_state = S_DST;
                    w_cnt   = '0;
                    w_data  = r_hdr[111:104];
                    w_hdr   = {r_hdr[103:0], 8'h00};
                    w_flags = 4'b0100;
                end else begin
                    w_cnt   = r_cnt + 16'd1;
                    w_data  = 8'h55;
                    w_flags = 4'b1000;
                end
            end
            S_DST, S_SRC: begin
                w_ctrl = 1'b1;
                w_data = r_hdr[111:104];
                w_hdr  = {r_hdr[103:0], 8'h00};
                if (r_cnt == 16'd5) begin
                    w_cnt = '0;
                    if (r_state == S_DST) begin
                        w_state = S_SRC;
                        w_flags = 4'b0010;
                    end else begin
                        w_state = S_TYPE;
                        w_flags = 4'b0001;
                    end
                end else begin
                    w_cnt   = r_cnt + 16'd1;
                    w_flags = r_flags;
                end
            end
            S_TYPE: begin
                if (r_cnt == 16'd0) begin
                    w_cnt   = 16'd1;
                    w_ctrl  = 1'b1;
                    w_data  = r_hdr[111:104];
                    w_hdr   = {r_hdr[103:0], 8'h00};
                    w_flags = 4'b0001;
                end else begin
                    w_take = 1'b1;
                end
            end
            S_PAY: begin
                if (r_last) w_finish = 1'b1;
                else        w_take   = 1'b1;
            end
`ifdef PAD_EN
            S_PAD: w_finish = 1'b1;
`endif
            S_GAP: begin
                if (r_cnt == IFG_LAST) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // payload_ready is high whenever w_take is set
        if (w_take) begin
            if (payload_valid) begin
                w_state = S_PAY;
                w_ctrl  = 1'b1;
                w_data  = payload_data;
                w_last  = payload_last;
                w_pcnt  = (r_pcnt == 11'h7FF) ? r_pcnt : r_pcnt + 11'd1;
            end else begin
                w_state = S_GAP;
                w_cnt   = '0;
                w_under = 1'b1;
            end
        end

        if (w_finish) begin
`ifdef PAD_EN
            if (r_pcnt < PAD_TARGET) begin
                w_state = S_PAD;
                w_ctrl  = 1'b1;
                w_data  = 8'h00;
                w_pcnt  = r_pcnt + 11'd1;
            end else
`endif
            begin
                w_state = S_GAP;
                w_cnt   = '0;
                w_done  = 1'b1;
                w_pkt   = r_pkt + 4'd1;
            end
        end
    end

    assign payload_ready = ((r_state == S_TYPE) && (r_cnt == 16'd1))
                        || ((r_state == S_PAY) && !r_last);
    assign data                 = r_data;
    assign control              = r_ctrl;
    assign preamble_valid       = r_flags[3];
    assign dst_addr_valid       = r_flags[2];
    assign src_addr_valid       = r_flags[1];
    assign type_length_valid    = r_flags[0];
    assign frame_done           = r_done;
    assign underrun             = r_under;
    assign busy                 = (r_state != S_IDLE);
    assign valid_packet_counter = r_pkt;

endmodule
